m_mem_arbiter: RTL and testbench



---
 rtl/m_arb_pkg.sv | 17 +
 rtl/m_arb_pick.sv | 20 ++
 rtl/m_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_m_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_arb_pkg.sv
// Shared encodings for the two-port memory arbiter (m_mem_arbiter and m_arb_pick).
package m_arb_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/m_arb_pick.sv
// Combinational winner selection: D has priority unless IF has waited MAX_WAIT D grants.
module m_arb_pick
    import m_arb_pkg::*;
#(
    parameter int MAX_WAIT = 3
) (
    input  logic              i_if_valid,
    input  logic              i_d_valid,
    input  logic [WAIT_W-1:0] i_wait_cnt,
    output logic              o_grant_if,
    output logic              o_grant_d
);

    logic w_force_if;

    assign w_force_if = (i_wait_cnt == WAIT_W'(MAX_WAIT));
    assign o_grant_if = i_if_valid && (w_force_if || !i_d_valid);
    assign o_grant_d  = i_d_valid && !o_grant_if;

endmodule

// File: rtl/m_mem_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and load/store (D).
// Optional grant statistics and starvation pulse are enabled with ARB_STATS_EN.
module m_mem_arbiter
    import m_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 3
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_if_valid,
    input  logic [ADDR_W-1:0] w_if_adr,
    output logic              w_if_ready,
    output logic              w_if_rvalid,
    output logic [DATA_W-1:0] w_if_rdata,
    input  logic              w_d_valid,
    input  logic              w_d_we,
    input  logic [ADDR_W-1:0] w_d_adr,
    input  logic [DATA_W-1:0] w_d_wd,
    output logic              w_d_ready,
    output logic              w_d_rvalid,
    output logic [DATA_W-1:0] w_d_rdata,
    output logic              w_mem_req,
    output logic              w_mem_we,
    output logic [ADDR_W-1:0] w_mem_adr,
    output logic [DATA_W-1:0] w_mem_wd,
`ifdef ARB_STATS_EN
    output logic [15:0]       w_if_grants,
    output logic [15:0]       w_d_grants,
    output logic              w_starve_evt,
`endif
    input  logic [DATA_W-1:0] w_mem_rd
);

    state_t            r_state;
    owner_t            r_owner;
    logic [2:0]        r_lat;
    logic [WAIT_W-1:0] r_wait;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic w_can_arb;
    logic w_resp;
    logic w_g_if;
    logic w_g_d;
    logic w_rd_grant;

    // A new access may start in IDLE and also in the response cycle itself.
    assign w_can_arb = !w_rst && (r_state != ST_WAIT);
    assign w_resp    = !w_rst && (r_state == ST_RESP);

    m_arb_pick #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .i_if_valid (w_if_valid && w_can_arb),
        .i_d_valid  (w_d_valid && w_can_arb),
        .i_wait_cnt (r_wait),
        .o_grant_if (w_g_if),
        .o_grant_d  (w_g_d)
    );

    assign w_rd_grant = w_g_if || (w_g_d && !w_d_we);

    assign w_if_ready = w_g_if;
    assign w_d_ready  = w_g_d;
    assign w_mem_req  = w_g_if || w_g_d;
    assign w_mem_we   = w_g_d && w_d_we;
    assign w_mem_adr  = w_g_d ? w_d_adr : (w_g_if ? w_if_adr : '0);
    assign w_mem_wd   = w_g_d ? w_d_wd : '0;

    // Read data is forwarded straight from memory in the response cycle, then held.
    assign w_if_rvalid = w_resp && (r_owner == OWN_IF);
    assign w_d_rvalid  = w_resp && (r_owner == OWN_D);
    assign w_if_rdata  = w_if_rvalid ? w_mem_rd : r_if_rdata;
    assign w_d_rdata   = w_d_rvalid ? w_mem_rd : r_d_rdata;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= OWN_IF;
            r_lat      <= 3'd0;
            r_wait     <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (w_if_rvalid) r_if_rdata <= w_mem_rd;
            if (w_d_rvalid)  r_d_rdata  <= w_mem_rd;

            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (w_rd_grant) begin
                        r_owner <= w_g_d ? OWN_D : OWN_IF;
                        r_lat   <= 3'(MEM_LAT - 1);
                        if (MEM_LAT == 1) r_state <= ST_RESP;
                        else              r_state <= ST_WAIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    r_lat <= r_lat - 3'd1;
                    if (r_lat == 3'd1) r_state <= ST_RESP;
                end
                default: r_state <= ST_IDLE;
            endcase

            // Starvation counter only tracks D grants that IF actually lost.
            if (!w_if_valid || w_g_if) r_wait <= '0;
            else if (w_g_d)            r_wait <= r_wait + WAIT_W'(1);
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] r_if_grants;
    logic [15:0] r_d_grants;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_if_grants <= '0;
            r_d_grants  <= '0;
        end else begin
            if (w_g_if && (r_if_grants != 16'hFFFF)) r_if_grants <= r_if_grants + 16'd1;
            if (w_g_d && (r_d_grants != 16'hFFFF))   r_d_grants  <= r_d_grants + 16'd1;
        end
    end

    assign w_if_grants  = r_if_grants;
    assign w_d_grants   = r_d_grants;
    assign w_starve_evt = w_g_if && w_d_valid && (r_wait == WAIT_W'(MAX_WAIT));
`endif

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Bench for m_mem_arbiter: cycle-level reference model of the arbitration rules plus a latency memory.
module tb_m_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int MAXW = 3;

    logic          clk;
    logic          rst;
    logic          if_valid;
    logic [AW-1:0] if_adr;
    logic          if_ready;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_valid;
    logic          d_we;
    logic [AW-1:0] d_adr;
    logic [DW-1:0] d_wd;
    logic          d_ready;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
`ifdef ARB_STATS_EN
    logic [15:0]   if_grants;
    logic [15:0]   d_grants;
    logic          starve_evt;
`endif

    m_mem_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MEM_LAT  (LAT),
        .MAX_WAIT (MAXW)
    ) u_dut (
        .w_clk       (clk),
        .w_rst       (rst),
        .w_if_valid  (if_valid),
        .w_if_adr    (if_adr),
        .w_if_ready  (if_ready),
        .w_if_rvalid (if_rvalid),
        .w_if_rdata  (if_rdata),
        .w_d_valid   (d_valid),
        .w_d_we      (d_we),
        .w_d_adr     (d_adr),
        .w_d_wd      (d_wd),
        .w_d_ready   (d_ready),
        .w_d_rvalid  (d_rvalid),
        .w_d_rdata   (d_rdata),
        .w_mem_req   (mem_req),
        .w_mem_we    (mem_we),
        .w_mem_adr   (mem_adr),
        .w_mem_wd    (mem_wd),
`ifdef ARB_STATS_EN
        .w_if_grants  (if_grants),
        .w_d_grants   (d_grants),
        .w_starve_evt (starve_evt),
`endif
        .w_mem_rd    (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory device: 64 words, word n = 0x100+n after reset, read data LAT cycles after request.
    logic [DW-1:0] mem [64];
    logic [DW-1:0] rd_pipe [LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h100 + i;
        end else if (mem_req && mem_we) begin
            mem[mem_adr[7:2]] <= mem_wd;
        end
        rd_pipe[0] <= (mem_req && !mem_we) ? mem[mem_adr[7:2]] : 32'hBAD0BAD0;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rd = rd_pipe[LAT-1];

    // Reference model state: outstanding read described by its due cycle.
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          m_pend = 1'b0;
    int          m_rsp_cyc = 0;
    bit          m_own_d = 1'b0;
    logic [31:0] m_rdata_pend = '0;
    int          m_starve = 0;
    logic [31:0] m_if_hold = '0;
    logic [31:0] m_d_hold = '0;
    logic [31:0] ref_mem [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(output bit gi, output bit gd, output bit oi, output bit od);
        bit          can;
        bit          rsp;
        logic [31:0] e_adr;
        logic [31:0] e_wd;
        @(negedge clk);
        can = !m_pend || (cyc == m_rsp_cyc);
        rsp = !rst && m_pend && (cyc == m_rsp_cyc);
        gi = 1'b0;
        gd = 1'b0;
        if (!rst && can) begin
            if (if_valid && (m_starve == MAXW || !d_valid)) gi = 1'b1;
            else if (d_valid)                                gd = 1'b1;
        end
        e_adr = gd ? d_adr : (gi ? if_adr : 32'h0);
        e_wd  = gd ? d_wd : 32'h0;
        oi = if_ready;
        od = d_ready;
        chk("if_ready",  32'(if_ready),  32'(gi));
        chk("d_ready",   32'(d_ready),   32'(gd));
        chk("mem_req",   32'(mem_req),   32'(gi || gd));
        chk("mem_we",    32'(mem_we),    32'(gd && d_we));
        chk("mem_adr",   mem_adr,        e_adr);
        chk("mem_wd",    mem_wd,         e_wd);
        chk("if_rvalid", 32'(if_rvalid), 32'(rsp && !m_own_d));
        chk("d_rvalid",  32'(d_rvalid),  32'(rsp && m_own_d));
        chk("if_rdata",  if_rdata, (rsp && !m_own_d) ? m_rdata_pend : m_if_hold);
        chk("d_rdata",   d_rdata,  (rsp && m_own_d) ? m_rdata_pend : m_d_hold);
`ifdef ARB_STATS_EN
        chk("starve_evt", 32'(starve_evt), 32'(gi && d_valid && m_starve == MAXW));
`endif
        if (rst) begin
            m_pend    = 1'b0;
            m_starve  = 0;
            m_if_hold = '0;
            m_d_hold  = '0;
            for (int i = 0; i < 64; i++) ref_mem[i] = 32'h100 + i;
        end else begin
            if (rsp) begin
                if (m_own_d) m_d_hold = m_rdata_pend;
                else         m_if_hold = m_rdata_pend;
                m_pend = 1'b0;
            end
            if (gd && d_we) begin
                ref_mem[d_adr[7:2]] = d_wd;
            end else if (gi || gd) begin
                m_pend       = 1'b1;
                m_rsp_cyc    = cyc + LAT;
                m_own_d      = gd;
                m_rdata_pend = ref_mem[e_adr[7:2]];
            end
            if (!if_valid || gi) m_starve = 0;
            else if (gd)         m_starve++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        bit       gi, gd, oi, od;
        int       ng;
        logic [7:0] seq;

        rst = 1'b1;
        if_valid = 1'b0; if_adr = '0;
        d_valid = 1'b0; d_we = 1'b0; d_adr = '0; d_wd = '0;
        step(gi, gd, oi, od);
        step(gi, gd, oi, od);
        rst = 1'b0;
        step(gi, gd, oi, od);

        // IF-only stream of three reads
        if_valid = 1'b1; if_adr = 32'h0; ng = 0;
        for (int k = 0; k < 20 && ng < 3; k++) begin
            step(gi, gd, oi, od);
            if (oi) begin
                ng++;
                if_adr = if_adr + 32'd4;
                if (ng == 3) if_valid = 1'b0;
            end
        end
        chk("if_stream_grants", 32'(ng), 32'd3);
        for (int k = 0; k < LAT; k++) step(gi, gd, oi, od);
        chk("if_stream_last", if_rdata, 32'h102);

        // D store then load of the same word
        d_valid = 1'b1; d_we = 1'b1; d_adr = 32'h10; d_wd = 32'hDEAD;
        step(gi, gd, oi, od);
        chk("store_ready", 32'(od), 32'd1);
        d_we = 1'b0; d_wd = 32'h0;
        step(gi, gd, oi, od);
        chk("load_ready", 32'(od), 32'd1);
        d_valid = 1'b0;
        for (int k = 0; k < LAT; k++) step(gi, gd, oi, od);
        chk("load_data", d_rdata, 32'hDEAD);

        // Both valid continuously: D stores vs IF reads
        if_valid = 1'b1; if_adr = 32'h0;
        d_valid = 1'b1; d_we = 1'b1; d_adr = 32'h80; d_wd = 32'h1;
        ng = 0; seq = '0;
        for (int k = 0; k < 40 && ng < 8; k++) begin
            step(gi, gd, oi, od);
            if (oi || od) begin
                seq = {seq[6:0], od};
                ng++;
                if (od) d_wd = d_wd + 32'd1;
            end
        end
        chk("grant_order", 32'(seq), 32'hEE);
        if_valid = 1'b0; d_valid = 1'b0;
        for (int k = 0; k < LAT + 1; k++) step(gi, gd, oi, od);

        // Reset one cycle after an IF read is accepted
        if_valid = 1'b1; if_adr = 32'hC;
        step(gi, gd, oi, od);
        chk("rst_case_accept", 32'(oi), 32'd1);
        if_valid = 1'b0; rst = 1'b1;
        step(gi, gd, oi, od);
        rst = 1'b0;
        step(gi, gd, oi, od);
        chk("rst_if_rdata", if_rdata, 32'h0);
        step(gi, gd, oi, od);
        if_valid = 1'b1; if_adr = 32'hC;
        step(gi, gd, oi, od);
        if_valid = 1'b0;
        for (int k = 0; k < LAT; k++) step(gi, gd, oi, od);
        chk("post_rst_read", if_rdata, 32'h103);

        // D request withdrawn while IF read is in flight: no store must happen
        if_valid = 1'b1; if_adr = 32'h20;
        step(gi, gd, oi, od);
        if_valid = 1'b0;
        d_valid = 1'b1; d_we = 1'b1; d_adr = 32'h30; d_wd = 32'hBEEF;
        step(gi, gd, oi, od);
        d_valid = 1'b0;
        step(gi, gd, oi, od);
        if_valid = 1'b1; if_adr = 32'h30;
        step(gi, gd, oi, od);
        if_valid = 1'b0;
        for (int k = 0; k < LAT; k++) step(gi, gd, oi, od);
        chk("withdraw_no_store", if_rdata, 32'h10C);

        // Randomized traffic obeying the hold-until-ready rule
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            step(gi, gd, oi, od);
            if (oi || !if_valid) begin
                if_valid = ($urandom_range(0, 2) != 0);
                if_adr   = $urandom();
            end else if ($urandom_range(0, 15) == 0) begin
                if_valid = 1'b0;
            end
            if (od || !d_valid) begin
                d_valid = ($urandom_range(0, 2) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_adr   = $urandom();
                d_wd    = $urandom();
            end else if ($urandom_range(0, 15) == 0) begin
                d_valid = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
